irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: N_CH, default 4, number of interrupt channels, legal range 1..16.
REQ-002 Parameter: EDGE_MODE, default 1; 1 = rising-edge-triggered channels, 0 = level-triggered channels.
REQ-003 Parameter: ID_W, default 2, width of irq_id; it SHALL equal max(1, clog2(N_CH)).
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: irq_in  in  N_CH  raw device requests, synchronous to clk.
REQ-007 Port: mask_we  in  1  write strobe for the enable-mask register.
REQ-008 Port: mask_wdata  in  N_CH  new enable mask; bit i = 1 enables channel i.
REQ-009 Port: PC31  in  1  kernel-mode flag of the current PC; no interrupt is raised while it is high.
REQ-010 Port: irq_ack  in  1  the core has taken the interrupt (decode issued PCSrc=100).
REQ-011 Port: eret  in  1  the handler has returned.
REQ-012 Port: IRQ  out  1  registered interrupt request to the decode/control stage.
REQ-013 Port: irq_id  out  ID_W  index of the channel being requested or serviced.
REQ-014 Port: pending  out  N_CH  current pending latches.
REQ-015 Port: in_service  out  1  a handler is active.

Function
REQ-016 irq_q SHALL register irq_in every cycle; rise = irq_in & ~irq_q.
REQ-017 Pending set SHALL be: EDGE_MODE=1 -> pending[i] set at the edge where rise[i]=1; EDGE_MODE=0 -> pending[i] set at every edge where irq_in[i]=1.
REQ-018 Pending clear SHALL occur only on acceptance (REQ-023); if set and clear of the same bit coincide, set wins.
REQ-019 mask SHALL load mask_wdata at the edge where mask_we=1; pending latching is independent of mask.
REQ-020 eligible = pending & mask; winner = lowest-index set bit of eligible (channel 0 highest priority).
REQ-021 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-022 IDLE: if eligible is nonzero and PC31=0 -> REQ, latching winner into irq_id; otherwise remain; irq_id=0.
REQ-023 REQ: IRQ=1 and irq_id is held; on irq_ack=1 -> SERVICE and clear pending[irq_id]; else if eligible[irq_id]=0 (masked off) -> IDLE with no acceptance.
REQ-024 REQ: irq_ack takes precedence over a same-cycle mask write that disables the channel.
REQ-025 SERVICE: in_service=1, IRQ=0, irq_id is held; on eret=1 -> IDLE. Nesting is not supported.
REQ-026 irq_ack is ignored outside REQ; eret is ignored outside SERVICE.
REQ-027 IRQ, irq_id and in_service SHALL be registered FSM outputs with no combinational path from any input.
REQ-028 Latency: with EDGE_MODE=1, irq_in rising before edge k sets pending after edge k and IRQ after edge k+1 (2 cycles).
REQ-029 After eret, a remaining eligible channel SHALL raise IRQ again 1 cycle after the return to IDLE, provided PC31=0.

Reset
REQ-030 On reset: state=IDLE, pending=0, mask=0, irq_q=0, IRQ=0, irq_id=0, in_service=0, all asynchronously.
REQ-031 Reset asserted mid-REQ or mid-SERVICE SHALL drop IRQ and in_service immediately and discard all pending state.
REQ-032 The first edge after reset release SHALL treat an irq_in already high as a rising edge.

Verification
REQ-033 Basic: mask=4'b1111, pulse irq_in[2] one cycle -> pending=4'b0100 after 1 edge; IRQ=1, irq_id=2 after 2 edges; irq_ack -> pending=0, in_service=1; eret -> IDLE.
REQ-034 Priority: irq_in[3] and irq_in[1] rise together -> irq_id=1; after the ack/eret sequence, IRQ is raised again with irq_id=3.
REQ-035 Gating: PC31=1 with pending[0] set and enabled -> IRQ stays 0; drop PC31 -> IRQ=1 one edge later; mask=0 leaves pending set with IRQ=0.
REQ-036 Collision: irq_in[2] re-rises in the same cycle as the irq_ack for channel 2 -> pending[2] remains 1 and is re-requested after eret.
REQ-037 Withdrawal/reset: in REQ, write mask=0 without an ack -> IDLE and IRQ=0; assert reset during SERVICE -> all outputs 0 without waiting for a clock edge.
REQ-038 Level mode: EDGE_MODE=0 with irq_in[0] held high -> pending[0] re-sets after the ack and the channel is re-requested after each eret.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches per-channel requests, masks and prioritises them (channel 0 highest), and runs an IDLE/REQ/SERVICE handshake with the core.
// Latency: an edge-mode request rising before edge k is pending after edge k; IRQ is asserted after edge k+1.
// Backpressure: IRQ is held until irq_ack; a handler in service blocks further requests until eret (no nesting).
module irq_ctrl #(
  parameter int N_CH      = 4,
  parameter int EDGE_MODE = 1,
  parameter int ID_W      = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] irq_in,
  input  logic            mask_we,
  input  logic [N_CH-1:0] mask_wdata,
  input  logic            PC31,
  input  logic            irq_ack,
  input  logic            eret,
  output logic            IRQ,
  output logic [ID_W-1:0] irq_id,
  output logic [N_CH-1:0] pending,
  output logic            in_service
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [N_CH-1:0] r_irq_q;
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_mask;
  logic            r_irq;
  logic [ID_W-1:0] r_id;
  logic            r_in_service;

  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_set;
  logic [N_CH-1:0] w_clr;
  logic [N_CH-1:0] w_eligible;
  logic            w_any;
  logic [ID_W-1:0] w_winner;
  logic            w_id_elig;
  logic            w_accept;
  logic            w_irq_d;
  logic            w_in_service_d;
  logic [ID_W-1:0] w_id_d;

  // Request conditioning: rising-edge detect or raw level, depending on channel mode.
  assign w_rise     = irq_in & ~r_irq_q;
  assign w_set      = (EDGE_MODE != 0) ? w_rise : irq_in;
  assign w_eligible = r_pending & r_mask;
  assign w_any      = |w_eligible;
  assign w_accept   = (r_state == S_REQ) && irq_ack;

  // Delay line for edge detection; zero after reset so a level already high counts as a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_q <= '0;
    end else begin
      r_irq_q <= irq_in;
    end
  end

  // Enable mask register, written directly by the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
    end else if (mask_we) begin
      r_mask <= mask_wdata;
    end
  end

  // Pending latches: cleared only on acceptance, and a coincident new request wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  // Fixed priority: the lowest-index eligible channel wins.
  always_comb begin
    w_winner = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = ID_W'(i);
      end
    end
  end

  // Decode the held id: is it still eligible, and which pending bit does acceptance clear.
  always_comb begin
    w_id_elig = 1'b0;
    w_clr     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_id == ID_W'(i)) begin
        w_id_elig = w_eligible[i];
        w_clr[i]  = w_accept;
      end
    end
  end

  // FSM state register together with the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_irq        <= 1'b0;
      r_id         <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_irq        <= w_irq_d;
      r_id         <= w_id_d;
      r_in_service <= w_in_service_d;
    end
  end

  // FSM next-state: ack beats withdrawal, so a same-cycle mask write cannot cancel an accepted interrupt.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any && !PC31) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          w_state_nxt = S_SERVICE;
        end else if (!w_id_elig) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eret) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so they can be registered alongside it.
  always_comb begin
    w_irq_d        = (w_state_nxt == S_REQ);
    w_in_service_d = (w_state_nxt == S_SERVICE);
    w_id_d         = r_id;
    if ((r_state == S_IDLE) && (w_state_nxt == S_REQ)) begin
      w_id_d = w_winner;
    end else if (w_state_nxt == S_IDLE) begin
      w_id_d = '0;
    end
  end

  assign IRQ        = r_irq;
  assign irq_id     = r_id;
  assign pending    = r_pending;
  assign in_service = r_in_service;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: edge-mode instance for the main sequences, level-mode instance for re-request behaviour.
// Inputs are driven 1 time unit after the rising edge; outputs are checked in the same window.
// Every comparison goes through chk(); the summary line reports errors and total checks.
module tb_irq_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       PC31;
  logic       irq_ack;
  logic       eret;
  logic       IRQ;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       in_service;

  logic       lv_reset;
  logic [3:0] lv_irq_in;
  logic       lv_mask_we;
  logic [3:0] lv_mask_wdata;
  logic       lv_PC31;
  logic       lv_irq_ack;
  logic       lv_eret;
  logic       lv_IRQ;
  logic [1:0] lv_irq_id;
  logic [3:0] lv_pending;
  logic       lv_in_service;

  int n_chk;
  int n_err;

  irq_ctrl #(.N_CH(4), .EDGE_MODE(1), .ID_W(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .PC31       (PC31),
    .irq_ack    (irq_ack),
    .eret       (eret),
    .IRQ        (IRQ),
    .irq_id     (irq_id),
    .pending    (pending),
    .in_service (in_service)
  );

  irq_ctrl #(.N_CH(4), .EDGE_MODE(0), .ID_W(2)) u_dut_lv (
    .clk        (clk),
    .reset      (lv_reset),
    .irq_in     (lv_irq_in),
    .mask_we    (lv_mask_we),
    .mask_wdata (lv_mask_wdata),
    .PC31       (lv_PC31),
    .irq_ack    (lv_irq_ack),
    .eret       (lv_eret),
    .IRQ        (lv_IRQ),
    .irq_id     (lv_irq_id),
    .pending    (lv_pending),
    .in_service (lv_in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the four observable outputs of the edge-mode instance at once.
  task automatic chk_all(input string tag, input logic e_irq, input logic [1:0] e_id,
                         input logic [3:0] e_pend, input logic e_svc);
    chk({tag, ".IRQ"},        32'(IRQ),        32'(e_irq));
    chk({tag, ".irq_id"},     32'(irq_id),     32'(e_id));
    chk({tag, ".pending"},    32'(pending),    32'(e_pend));
    chk({tag, ".in_service"}, 32'(in_service), 32'(e_svc));
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic ack_cycle();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic eret_cycle();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    PC31 = 1'b0; irq_ack = 1'b0; eret = 1'b0;
    lv_reset = 1'b1; lv_irq_in = '0; lv_mask_we = 1'b0; lv_mask_wdata = '0;
    lv_PC31 = 1'b0; lv_irq_ack = 1'b0; lv_eret = 1'b0;

    // Reset state
    #1;
    chk_all("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    tick(); tick();
    reset = 1'b0;
    write_mask(4'b1111);

    // Basic single-channel flow with 2-cycle latency
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    chk_all("basic_pend", 1'b0, 2'd0, 4'b0100, 1'b0);
    tick();
    chk_all("basic_req", 1'b1, 2'd2, 4'b0100, 1'b0);
    ack_cycle();
    chk_all("basic_svc", 1'b0, 2'd2, 4'b0000, 1'b1);
    eret_cycle();
    chk_all("basic_idle", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Priority: channels 3 and 1 together, 1 first then 3
    irq_in = 4'b1010;
    tick();
    irq_in = 4'b0000;
    tick();
    chk_all("prio_first", 1'b1, 2'd1, 4'b1010, 1'b0);
    ack_cycle();
    chk("prio_svc.pending", 32'(pending), 32'(4'b1000));
    eret_cycle();
    chk("prio_idle.IRQ", 32'(IRQ), 32'(1'b0));
    tick();
    chk_all("prio_second", 1'b1, 2'd3, 4'b1000, 1'b0);
    ack_cycle();
    eret_cycle();

    // Gating by PC31
    PC31 = 1'b1;
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick(); tick();
    chk_all("pc31_block", 1'b0, 2'd0, 4'b0001, 1'b0);
    PC31 = 1'b0;
    tick();
    chk_all("pc31_release", 1'b1, 2'd0, 4'b0001, 1'b0);
    ack_cycle();
    eret_cycle();

    // Gating by mask: pending latches but no request
    write_mask(4'b0000);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick(); tick();
    chk_all("mask_block", 1'b0, 2'd0, 4'b0001, 1'b0);
    write_mask(4'b1111);
    tick();
    chk_all("mask_release", 1'b1, 2'd0, 4'b0001, 1'b0);
    ack_cycle();
    eret_cycle();

    // Collision: re-rise of channel 2 in the ack cycle survives the clear
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("coll_req.irq_id", 32'(irq_id), 32'(2'd2));
    irq_ack = 1'b1;
    irq_in  = 4'b0100;
    tick();
    irq_ack = 1'b0;
    irq_in  = 4'b0000;
    chk_all("coll_svc", 1'b0, 2'd2, 4'b0100, 1'b1);
    eret_cycle();
    chk("coll_idle.IRQ", 32'(IRQ), 32'(1'b0));
    tick();
    chk_all("coll_rereq", 1'b1, 2'd2, 4'b0100, 1'b0);
    ack_cycle();
    eret_cycle();

    // Withdrawal: masking the requested channel without an ack returns to IDLE
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("wd_req.IRQ", 32'(IRQ), 32'(1'b1));
    write_mask(4'b0000);
    chk("wd_maskedge.IRQ", 32'(IRQ), 32'(1'b1));
    tick();
    chk_all("wd_idle", 1'b0, 2'd0, 4'b0010, 1'b0);

    // Ack wins over a same-cycle disabling mask write
    write_mask(4'b1111);
    tick();
    chk("ackwin_req.irq_id", 32'(irq_id), 32'(2'd1));
    irq_ack    = 1'b1;
    mask_we    = 1'b1;
    mask_wdata = 4'b0000;
    tick();
    irq_ack = 1'b0;
    mask_we = 1'b0;
    chk_all("ackwin_svc", 1'b0, 2'd1, 4'b0000, 1'b1);

    // Asynchronous reset during SERVICE, away from any clock edge
    #2;
    reset  = 1'b1;
    irq_in = 4'b1000;
    #1;
    chk_all("async_rst", 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    reset = 1'b0;
    // irq_in[3] already high across release counts as a rise
    tick();
    chk("rst_rise.pending", 32'(pending), 32'(4'b1000));
    irq_in = 4'b0000;

    // Level mode: held request re-sets pending after ack and re-requests after each eret
    lv_reset      = 1'b0;
    lv_mask_we    = 1'b1;
    lv_mask_wdata = 4'b1111;
    lv_irq_in     = 4'b0001;
    tick();
    lv_mask_we = 1'b0;
    chk("lv_pend", 32'(lv_pending), 32'(4'b0001));
    tick();
    chk("lv_req.IRQ", 32'(lv_IRQ), 32'(1'b1));
    for (int r = 0; r < 2; r++) begin
      lv_irq_ack = 1'b1;
      tick();
      lv_irq_ack = 1'b0;
      chk("lv_svc.pending", 32'(lv_pending), 32'(4'b0001));
      chk("lv_svc.in_service", 32'(lv_in_service), 32'(1'b1));
      lv_eret = 1'b1;
      tick();
      lv_eret = 1'b0;
      chk("lv_idle.IRQ", 32'(lv_IRQ), 32'(1'b0));
      tick();
      chk("lv_rereq.IRQ", 32'(lv_IRQ), 32'(1'b1));
      chk("lv_rereq.irq_id", 32'(lv_irq_id), 32'(2'd0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
